// File: rtl/snax_cgra_pkg.sv
// snax_cgra_pkg: shared types and constants for the CGRA stream buffer.
//   csr_state_e  : host CSR write FSM states (IDLE, REQ)
//   CsrWidth     : CSR word width
//   CntWidth     : performance counter width
//   PerfCntWords : extra read-only CSR words added when SNAX_CGRA_PERF_CNT_EN is defined
//   popcount16   : beats-per-cycle helper for the performance counters
package snax_cgra_pkg;

  localparam int unsigned CsrWidth = 32;
  localparam int unsigned CntWidth = 32;

`ifdef SNAX_CGRA_PERF_CNT_EN
  localparam int unsigned PerfCntWords = 2;
`else
  localparam int unsigned PerfCntWords = 0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } csr_state_e;

  function automatic logic [CntWidth-1:0] popcount16(input logic [15:0] v);
    logic [CntWidth-1:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {{(CntWidth-1){1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/snax_cgra_stream_fifo.sv
// snax_cgra_stream_fifo: single-clock FIFO for one stream channel.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     : upstream handshake, in_ready = not full
//   out_data/out_valid/out_ready  : downstream handshake, out_valid = not empty
// No bypass: a beat is visible at the output one cycle after it is accepted,
// and a full FIFO refuses a push even while it is being popped.
module snax_cgra_stream_fifo #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  // MSB of each pointer is the wrap bit that separates full from empty
  logic [AddrW:0]         wr_ptr, rd_ptr;
  logic [DataWidth-1:0]   mem [FifoDepth];
  logic                   full, empty, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                 (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // storage carries no reset; pointers alone define what is valid
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AddrW-1:0]] <= in_data;
  end

endmodule

// File: rtl/snax_cgra_stream_buffer.sv
// snax_cgra_stream_buffer: decouples the SNAX streamers from the CGRA core.
//   stream2acc_*  -> per-channel FIFO -> cgra_in_*      (NumIn channels)
//   cgra_out_*    -> per-channel FIFO -> acc2stream_*   (NumOut channels)
//   csr_reg_set_* : host RW CSR write, forwarded to the core via a 2-state
//                   FSM on cgra_csr_rw_* (held stable until ack)
//   cgra_csr_ro_i : core status words, passed to csr_reg_ro_set_o
// Optional feature macro SNAX_CGRA_PERF_CNT_EN: two 32-bit beat counters
// (stream2acc accepts, acc2stream accepts) appended after the core status
// words; both clear on every accepted host CSR write.
module snax_cgra_stream_buffer
  import snax_cgra_pkg::*;
#(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumIn        = 8,
  parameter int unsigned NumOut       = 8,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned NumRwCsr     = 1,
  parameter int unsigned NumCoreRoCsr = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumIn-1:0][DataWidth-1:0]        stream2acc_data_i,
  input  logic [NumIn-1:0]                       stream2acc_valid_i,
  output logic [NumIn-1:0]                       stream2acc_ready_o,
  output logic [NumIn-1:0][DataWidth-1:0]        cgra_in_data_o,
  output logic [NumIn-1:0]                       cgra_in_valid_o,
  input  logic [NumIn-1:0]                       cgra_in_ready_i,
  input  logic [NumOut-1:0][DataWidth-1:0]       cgra_out_data_i,
  input  logic [NumOut-1:0]                      cgra_out_valid_i,
  output logic [NumOut-1:0]                      cgra_out_ready_o,
  output logic [NumOut-1:0][DataWidth-1:0]       acc2stream_data_o,
  output logic [NumOut-1:0]                      acc2stream_valid_o,
  input  logic [NumOut-1:0]                      acc2stream_ready_i,
  input  logic [NumRwCsr-1:0][CsrWidth-1:0]      csr_reg_set_i,
  input  logic                                   csr_reg_set_valid_i,
  output logic                                   csr_reg_set_ready_o,
  output logic [NumRwCsr-1:0][CsrWidth-1:0]      cgra_csr_rw_o,
  output logic                                   cgra_csr_rw_valid_o,
  input  logic                                   cgra_csr_rw_ack_i,
  input  logic [NumCoreRoCsr-1:0][CsrWidth-1:0]  cgra_csr_ro_i,
  output logic [NumCoreRoCsr+PerfCntWords-1:0][CsrWidth-1:0] csr_reg_ro_set_o
);

  // ---------------- stream FIFOs ----------------
  for (genvar i = 0; i < NumIn; i++) begin : g_in
    snax_cgra_stream_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_data   (stream2acc_data_i[i]),
      .in_valid  (stream2acc_valid_i[i]),
      .in_ready  (stream2acc_ready_o[i]),
      .out_data  (cgra_in_data_o[i]),
      .out_valid (cgra_in_valid_o[i]),
      .out_ready (cgra_in_ready_i[i])
    );
  end

  for (genvar i = 0; i < NumOut; i++) begin : g_out
    snax_cgra_stream_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_data   (cgra_out_data_i[i]),
      .in_valid  (cgra_out_valid_i[i]),
      .in_ready  (cgra_out_ready_o[i]),
      .out_data  (acc2stream_data_o[i]),
      .out_valid (acc2stream_valid_o[i]),
      .out_ready (acc2stream_ready_i[i])
    );
  end

  // ---------------- CSR write FSM ----------------
  csr_state_e                          state;
  logic [NumRwCsr-1:0][CsrWidth-1:0]   csr_hold;
  logic                                set_ready_q, rw_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      csr_hold    <= '0;
      set_ready_q <= 1'b1;
      rw_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (csr_reg_set_valid_i) begin
          csr_hold    <= csr_reg_set_i;
          state       <= REQ;
          set_ready_q <= 1'b0;
          rw_valid_q  <= 1'b1;
        end
        REQ: if (cgra_csr_rw_ack_i) begin
          state       <= IDLE;
          set_ready_q <= 1'b1;
          rw_valid_q  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          set_ready_q <= 1'b1;
          rw_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign csr_reg_set_ready_o = set_ready_q;
  assign cgra_csr_rw_valid_o = rw_valid_q;
  assign cgra_csr_rw_o       = csr_hold;

  // ---------------- read-only CSR words ----------------
  for (genvar k = 0; k < NumCoreRoCsr; k++) begin : g_ro
    assign csr_reg_ro_set_o[k] = cgra_csr_ro_i[k];
  end

`ifdef SNAX_CGRA_PERF_CNT_EN
  logic [CntWidth-1:0] in_cnt, out_cnt;
  logic [15:0]         in_acc, out_acc;
  logic                csr_wr_acc;

  assign csr_wr_acc = csr_reg_set_valid_i & csr_reg_set_ready_o;

  // accepted beats per cycle, zero-padded to the helper's 16-lane input
  always_comb begin
    in_acc  = '0;
    out_acc = '0;
    in_acc[NumIn-1:0]   = stream2acc_valid_i & stream2acc_ready_o;
    out_acc[NumOut-1:0] = acc2stream_valid_o & acc2stream_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (csr_wr_acc) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      in_cnt  <= in_cnt + popcount16(in_acc);
      out_cnt <= out_cnt + popcount16(out_acc);
    end
  end

  assign csr_reg_ro_set_o[NumCoreRoCsr]   = in_cnt;
  assign csr_reg_ro_set_o[NumCoreRoCsr+1] = out_cnt;
`endif

endmodule

// File: tb/tb_snax_cgra_stream_buffer.sv
// Scoreboard bench for snax_cgra_stream_buffer: drivers push expected beats /
// CSR words into queues at acceptance; a negedge monitor pops and compares
// whenever a downstream handshake fires.
module tb_snax_cgra_stream_buffer;
  import snax_cgra_pkg::*;

  localparam int DW = 64, NIN = 8, NOUT = 8, DEPTH = 4, NRW = 1, NRO = 4;
  localparam int NROT = NRO + PerfCntWords;

  typedef struct {
    int          ch;
    logic [63:0] d;
  } beat_t;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [NIN-1:0][DW-1:0]    stream2acc_data_i;
  logic [NIN-1:0]            stream2acc_valid_i;
  logic [NIN-1:0]            stream2acc_ready_o;
  logic [NIN-1:0][DW-1:0]    cgra_in_data_o;
  logic [NIN-1:0]            cgra_in_valid_o;
  logic [NIN-1:0]            cgra_in_ready_i;
  logic [NOUT-1:0][DW-1:0]   cgra_out_data_i;
  logic [NOUT-1:0]           cgra_out_valid_i;
  logic [NOUT-1:0]           cgra_out_ready_o;
  logic [NOUT-1:0][DW-1:0]   acc2stream_data_o;
  logic [NOUT-1:0]           acc2stream_valid_o;
  logic [NOUT-1:0]           acc2stream_ready_i;
  logic [NRW-1:0][31:0]      csr_reg_set_i;
  logic                      csr_reg_set_valid_i;
  logic                      csr_reg_set_ready_o;
  logic [NRW-1:0][31:0]      cgra_csr_rw_o;
  logic                      cgra_csr_rw_valid_o;
  logic                      cgra_csr_rw_ack_i;
  logic [NRO-1:0][31:0]      cgra_csr_ro_i;
  logic [NROT-1:0][31:0]     csr_reg_ro_set_o;

  snax_cgra_stream_buffer #(
    .DataWidth(DW), .NumIn(NIN), .NumOut(NOUT), .FifoDepth(DEPTH),
    .NumRwCsr(NRW), .NumCoreRoCsr(NRO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stream2acc_data_i(stream2acc_data_i), .stream2acc_valid_i(stream2acc_valid_i),
    .stream2acc_ready_o(stream2acc_ready_o),
    .cgra_in_data_o(cgra_in_data_o), .cgra_in_valid_o(cgra_in_valid_o),
    .cgra_in_ready_i(cgra_in_ready_i),
    .cgra_out_data_i(cgra_out_data_i), .cgra_out_valid_i(cgra_out_valid_i),
    .cgra_out_ready_o(cgra_out_ready_o),
    .acc2stream_data_o(acc2stream_data_o), .acc2stream_valid_o(acc2stream_valid_o),
    .acc2stream_ready_i(acc2stream_ready_i),
    .csr_reg_set_i(csr_reg_set_i), .csr_reg_set_valid_i(csr_reg_set_valid_i),
    .csr_reg_set_ready_o(csr_reg_set_ready_o),
    .cgra_csr_rw_o(cgra_csr_rw_o), .cgra_csr_rw_valid_o(cgra_csr_rw_valid_o),
    .cgra_csr_rw_ack_i(cgra_csr_rw_ack_i),
    .cgra_csr_ro_i(cgra_csr_ro_i), .csr_reg_ro_set_o(csr_reg_ro_set_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0, errors = 0;
  beat_t       exp_in[$], exp_out[$];
  logic [31:0] exp_csr[$];
  int          in_pops[NIN]   = '{default: 0};
  int          out_pops[NOUT] = '{default: 0};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // ---------------- monitor ----------------
  int idx;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int c = 0; c < NIN; c++) if (cgra_in_valid_o[c] && cgra_in_ready_i[c]) begin
        in_pops[c]++;
        idx = -1;
        for (int j = 0; j < exp_in.size(); j++) if (exp_in[j].ch == c) begin idx = j; break; end
        if (idx < 0) begin
          checks++; errors++;
          $display("FAIL in_beat ch%0d: got %h expected no beat", c, cgra_in_data_o[c]);
        end else begin
          chk($sformatf("in_beat ch%0d", c), cgra_in_data_o[c], exp_in[idx].d);
          exp_in.delete(idx);
        end
      end
      for (int c = 0; c < NOUT; c++) if (acc2stream_valid_o[c] && acc2stream_ready_i[c]) begin
        out_pops[c]++;
        idx = -1;
        for (int j = 0; j < exp_out.size(); j++) if (exp_out[j].ch == c) begin idx = j; break; end
        if (idx < 0) begin
          checks++; errors++;
          $display("FAIL out_beat ch%0d: got %h expected no beat", c, acc2stream_data_o[c]);
        end else begin
          chk($sformatf("out_beat ch%0d", c), acc2stream_data_o[c], exp_out[idx].d);
          exp_out.delete(idx);
        end
      end
      if (cgra_csr_rw_valid_o && cgra_csr_rw_ack_i) begin
        if (exp_csr.size() == 0) begin
          checks++; errors++;
          $display("FAIL csr_rw: got %h expected no write", cgra_csr_rw_o[0]);
        end else begin
          chk("csr_rw", {32'h0, cgra_csr_rw_o[0]}, {32'h0, exp_csr.pop_front()});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_in(input int ch, input logic [63:0] d);
    int n;
    n = 0;
    stream2acc_data_i[ch]  = d;
    stream2acc_valid_i[ch] = 1'b1;
    @(negedge clk_i);
    while (!stream2acc_ready_o[ch] && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) timeout($sformatf("send_in ch%0d", ch));
    else exp_in.push_back('{ch: ch, d: d});
    @(posedge clk_i); #1;
    stream2acc_valid_i[ch] = 1'b0;
  endtask

  task automatic send_out(input int ch, input logic [63:0] d);
    int n;
    n = 0;
    cgra_out_data_i[ch]  = d;
    cgra_out_valid_i[ch] = 1'b1;
    @(negedge clk_i);
    while (!cgra_out_ready_o[ch] && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) timeout($sformatf("send_out ch%0d", ch));
    else exp_out.push_back('{ch: ch, d: d});
    @(posedge clk_i); #1;
    cgra_out_valid_i[ch] = 1'b0;
  endtask

  task automatic csr_write(input logic [31:0] d);
    int n;
    n = 0;
    csr_reg_set_i[0]    = d;
    csr_reg_set_valid_i = 1'b1;
    @(negedge clk_i);
    while (!csr_reg_set_ready_o && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) timeout("csr_write");
    else exp_csr.push_back(d);
    @(posedge clk_i); #1;
    csr_reg_set_valid_i = 1'b0;
  endtask

  task automatic ack_one();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!cgra_csr_rw_valid_o && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) timeout("ack_one");
    @(posedge clk_i); #1;
    cgra_csr_rw_ack_i = 1'b1;
    @(posedge clk_i); #1;
    cgra_csr_rw_ack_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    stream2acc_data_i = '0; stream2acc_valid_i = '0; cgra_in_ready_i = '1;
    cgra_out_data_i = '0; cgra_out_valid_i = '0; acc2stream_ready_i = '1;
    csr_reg_set_i = '0; csr_reg_set_valid_i = 1'b0; cgra_csr_rw_ack_i = 1'b0;
    cgra_csr_ro_i = '0;

    // reset values
    #12;
    chk("rst cgra_in_valid", cgra_in_valid_o, '0);
    chk("rst acc2stream_valid", acc2stream_valid_o, '0);
    chk("rst stream2acc_ready", stream2acc_ready_o, 8'hFF);
    chk("rst cgra_out_ready", cgra_out_ready_o, 8'hFF);
    chk("rst csr_set_ready", csr_reg_set_ready_o, 1);
    chk("rst rw_valid", cgra_csr_rw_valid_o, 0);
    chk("rst rw_data", cgra_csr_rw_o[0], 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // in-order delivery and one-cycle latency on ch0
    stream2acc_data_i[0] = 64'h11; stream2acc_valid_i[0] = 1'b1;
    @(negedge clk_i);
    chk("lat same-cycle valid", cgra_in_valid_o[0], 0);
    chk("lat ready", stream2acc_ready_o[0], 1);
    exp_in.push_back('{ch: 0, d: 64'h11});
    @(posedge clk_i); #1; stream2acc_valid_i[0] = 1'b0;
    @(negedge clk_i);
    chk("lat next-cycle valid", cgra_in_valid_o[0], 1);
    @(posedge clk_i); #1;
    send_in(0, 64'h22); send_in(0, 64'h33); send_in(0, 64'h44);
    repeat (3) @(posedge clk_i);
    chk("ch0 delivered", in_pops[0], 4);

    // backpressure: 5 beats into a 4-deep FIFO on ch3
    #1 cgra_in_ready_i[3] = 1'b0;
    for (int i = 0; i < 4; i++) send_in(3, 64'h300 + i);
    @(negedge clk_i);
    chk("ch3 full ready", stream2acc_ready_o[3], 0);
    @(posedge clk_i); #1;
    fork
      send_in(3, 64'h304);
      begin repeat (3) @(posedge clk_i); #1 cgra_in_ready_i[3] = 1'b1; end
    join
    repeat (8) @(posedge clk_i);
    chk("ch3 delivered", in_pops[3], 5);

    // full FIFO with simultaneous pop and push attempt on ch1
    #1 cgra_in_ready_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) send_in(1, 64'hA10 + i);
    cgra_in_ready_i[1] = 1'b1;
    stream2acc_data_i[1] = 64'hBAD; stream2acc_valid_i[1] = 1'b1;
    @(negedge clk_i);
    chk("full no-bypass ready", stream2acc_ready_o[1], 0);
    @(posedge clk_i); #1;
    stream2acc_valid_i[1] = 1'b0; cgra_in_ready_i[1] = 1'b0;
    @(negedge clk_i);
    chk("after pop ready", stream2acc_ready_o[1], 1);
    chk("after pop valid", cgra_in_valid_o[1], 1);
    @(posedge clk_i); #1 cgra_in_ready_i[1] = 1'b1;
    repeat (6) @(posedge clk_i);
    chk("ch1 delivered", in_pops[1], 4);

    // output path, two channels interleaved
    #1;
    fork
      for (int i = 0; i < 4; i++) send_out(2, 64'hB20 + i);
      for (int i = 0; i < 3; i++) send_out(5, 64'hB50 + i);
    join
    repeat (4) @(posedge clk_i);
    chk("out ch2 delivered", out_pops[2], 4);
    chk("out ch5 delivered", out_pops[5], 3);

    // reset with two beats queued on output ch7
    #1 acc2stream_ready_i[7] = 1'b0;
    send_out(7, 64'h70); send_out(7, 64'h71);
    @(negedge clk_i);
    chk("ch7 queued valid", acc2stream_valid_o[7], 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ch7 async reset valid", acc2stream_valid_o[7], 0);
    chk("reset cgra_out_ready", cgra_out_ready_o, 8'hFF);
    for (int j = exp_out.size() - 1; j >= 0; j--) if (exp_out[j].ch == 7) exp_out.delete(j);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; acc2stream_ready_i[7] = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("ch7 beats discarded", acc2stream_valid_o[7], 0);
    chk("ch7 nothing delivered", out_pops[7], 0);

    // status passthrough
    @(posedge clk_i); #1;
    for (int k = 0; k < NRO; k++) cgra_csr_ro_i[k] = 32'h1000_0000 + k * 32'h11;
    #1;
    chk("ro word0", csr_reg_ro_set_o[0], 32'h1000_0000);
    chk("ro word3", csr_reg_ro_set_o[3], 32'h1000_0033);

    // ack while IDLE is ignored
    @(posedge clk_i); #1 cgra_csr_rw_ack_i = 1'b1;
    @(negedge clk_i);
    chk("idle ack ready", csr_reg_set_ready_o, 1);
    @(posedge clk_i); #1 cgra_csr_rw_ack_i = 1'b0;
    @(negedge clk_i);
    chk("idle ack rw_valid", cgra_csr_rw_valid_o, 0);

    // CSR write with ack after 3 cycles; second write waits for IDLE
    @(posedge clk_i); #1;
    fork
      begin csr_write(32'hCAFE_0001); csr_write(32'h1234_5678); end
      begin
        int n;
        n = 0;
        @(negedge clk_i);
        while (!cgra_csr_rw_valid_o && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) timeout("csr req");
        chk("csr c1 valid", cgra_csr_rw_valid_o, 1);
        chk("csr c1 data", cgra_csr_rw_o[0], 32'hCAFE_0001);
        chk("csr c1 ready", csr_reg_set_ready_o, 0);
        @(negedge clk_i);
        chk("csr c2 valid", cgra_csr_rw_valid_o, 1);
        chk("csr c2 data", cgra_csr_rw_o[0], 32'hCAFE_0001);
        chk("csr c2 ready", csr_reg_set_ready_o, 0);
        @(posedge clk_i); #1 cgra_csr_rw_ack_i = 1'b1;
        @(negedge clk_i);
        chk("csr c3 valid", cgra_csr_rw_valid_o, 1);
        chk("csr c3 ready", csr_reg_set_ready_o, 0);
        @(posedge clk_i); #1 cgra_csr_rw_ack_i = 1'b0;
        @(negedge clk_i);
        chk("csr back idle", cgra_csr_rw_valid_o, 0);
        chk("csr idle ready", csr_reg_set_ready_o, 1);
        ack_one();
      end
    join
    @(negedge clk_i);
    chk("csr second data held", cgra_csr_rw_o[0], 32'h1234_5678);

`ifdef SNAX_CGRA_PERF_CNT_EN
    @(posedge clk_i); #1;
    fork csr_write(32'h1); ack_one(); join
    fork
      for (int i = 0; i < 5; i++) send_in(0, 64'hC00 + i);
      for (int i = 0; i < 5; i++) send_in(4, 64'hC40 + i);
      for (int i = 0; i < 6; i++) send_out(2, 64'hD20 + i);
    join
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("perf in count", csr_reg_ro_set_o[NRO], 10);
    chk("perf out count", csr_reg_ro_set_o[NRO+1], 6);
    @(posedge clk_i); #1;
    fork csr_write(32'h2); ack_one(); join
    @(negedge clk_i);
    chk("perf in cleared", csr_reg_ro_set_o[NRO], 0);
    chk("perf out cleared", csr_reg_ro_set_o[NRO+1], 0);
`endif

    repeat (5) @(posedge clk_i);
    chk("exp_in drained", exp_in.size(), 0);
    chk("exp_out drained", exp_out.size(), 0);
    chk("exp_csr drained", exp_csr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
